// File: rtl/gam_pattern_sequencer_pkg.sv
// Shared types for the GAM memory pipeline: pattern vectors, the Memory_Layer
// handshake and mode enums, and the pattern sequencer state encoding.
package GAM_package;

  typedef logic [31:0] node_vector_T;

  typedef enum logic {READY = 1'b0, WAIT = 1'b1} READY_WAIT_T;

  typedef enum logic {LEARNING = 1'b0, RECALL = 1'b1} LEARNING_RECALL_T;

  typedef enum logic [1:0] {IDLE, FEED, ACK, DONE} SEQ_STATE_T;

endpackage

// File: rtl/gam_pattern_sequencer_if.sv
// Link between the pattern sequencer (master) and Memory_Layer (slave):
// pattern/class delivery, the ready_wait handshake and the learning/recall mode.
interface gam_pattern_sequencer_if;
  import GAM_package::*;

  node_vector_T     x;
  int               c;
  logic             x_valid;
  logic             learning_done;
  LEARNING_RECALL_T learning_recall;
  READY_WAIT_T      ready_wait;

  modport master (
    output x, c, x_valid, learning_done, learning_recall,
    input  ready_wait
  );

  modport slave (
    input  x, c, x_valid, learning_done, learning_recall,
    output ready_wait
  );

endinterface

// File: rtl/gam_pattern_sequencer_store.sv
// Pattern register file, CLASS_COUNT x NODE_COUNT entries addressed 1-based by
// (class, node); one write port and one combinational read port. Contents are not reset.
module gam_pattern_store
  import GAM_package::*;
#(
  parameter int CLASS_COUNT = 4,
  parameter int NODE_COUNT  = 16
) (
  input  logic                              clk,
  input  logic                              we,
  input  logic [$clog2(CLASS_COUNT+1)-1:0]  wr_class,
  input  logic [$clog2(NODE_COUNT+1)-1:0]   wr_node,
  input  node_vector_T                      wr_data,
  input  logic [$clog2(CLASS_COUNT+1)-1:0]  rd_class,
  input  logic [$clog2(NODE_COUNT+1)-1:0]   rd_node,
  output node_vector_T                      rd_data
);

  localparam int CW    = $clog2(CLASS_COUNT+1);
  localparam int NW    = $clog2(NODE_COUNT+1);
  localparam int DEPTH = CLASS_COUNT * NODE_COUNT;
  localparam int AW    = $clog2(DEPTH);

  node_vector_T  mem_q [DEPTH];
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic          rd_ok;

  // Indices arrive 1-based; the caller only asserts we for in-range indices.
  assign wr_addr = AW'((int'(wr_class) - 1) * NODE_COUNT + (int'(wr_node) - 1));
  assign rd_addr = AW'((int'(rd_class) - 1) * NODE_COUNT + (int'(rd_node) - 1));

  assign rd_ok = (rd_class != '0) && (rd_class <= CW'(CLASS_COUNT)) &&
                 (rd_node  != '0) && (rd_node  <= NW'(NODE_COUNT));

  assign rd_data = rd_ok ? mem_q[rd_addr] : '0;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/gam_pattern_sequencer.sv
// Feeds host-loaded training patterns to Memory_Layer one at a time over the
// ready_wait handshake, then switches to RECALL and forwards recall probes.
module gam_pattern_sequencer
  import GAM_package::*;
#(
  parameter int CLASS_COUNT = 4,
  parameter int NODE_COUNT  = 16,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              wr_en,
  input  logic [$clog2(CLASS_COUNT+1)-1:0]  wr_class,
  input  logic [$clog2(NODE_COUNT+1)-1:0]   wr_node,
  input  node_vector_T                      wr_data,
  input  logic                              cnt_we,
  input  logic [$clog2(NODE_COUNT+1)-1:0]   cnt_data,
  input  logic                              start,
  input  logic                              abort,
  input  logic                              recall_we,
  input  node_vector_T                      recall_x,
  gam_pattern_sequencer_if.master           ml,
  output logic                              busy,
  output logic                              err
);

  localparam int CW = $clog2(CLASS_COUNT+1);
  localparam int NW = $clog2(NODE_COUNT+1);
  localparam int TW = $clog2(ACK_TIMEOUT);

  SEQ_STATE_T       state_q, state_d;
  logic [CW-1:0]    cls_q, cls_d;
  logic [NW-1:0]    node_q, node_d;
  logic             last_q, last_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [NW-1:0]    cnt_q [CLASS_COUNT+1];
  logic [NW-1:0]    cnt_d [CLASS_COUNT+1];

  node_vector_T     x_q, x_d;
  int               c_q, c_d;
  logic             x_valid_q, x_valid_d;
  logic             done_q, done_d;
  LEARNING_RECALL_T lr_q, lr_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic             writes_open, class_ok, node_ok;
  logic             store_we, cnt_ok, wr_reject;
  logic [NW-1:0]    cur_cnt;
  logic             any_nonempty, later_nonempty;
  node_vector_T     rd_data;

  assign writes_open = (state_q == IDLE) || (state_q == DONE);
  assign class_ok    = (wr_class != '0) && (wr_class <= CW'(CLASS_COUNT));
  assign node_ok     = (wr_node  != '0) && (wr_node  <= NW'(NODE_COUNT));
  assign store_we    = wr_en  && writes_open && class_ok && node_ok;
  assign cnt_ok      = cnt_we && writes_open && class_ok;
  assign wr_reject   = (wr_en && !store_we) || (cnt_we && !cnt_ok);
  assign cur_cnt     = (cls_q <= CW'(CLASS_COUNT)) ? cnt_q[cls_q] : '0;

  gam_pattern_store #(
    .CLASS_COUNT (CLASS_COUNT),
    .NODE_COUNT  (NODE_COUNT)
  ) u_store (
    .clk      (clk),
    .we       (store_we),
    .wr_class (wr_class),
    .wr_node  (wr_node),
    .wr_data  (wr_data),
    .rd_class (cls_q),
    .rd_node  (node_q),
    .rd_data  (rd_data)
  );

  // Emptiness scan uses the post-write counts so a count written with start takes effect.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_ok) begin
      cnt_d[wr_class] = (cnt_data > NW'(NODE_COUNT)) ? NW'(NODE_COUNT) : cnt_data;
    end
    any_nonempty   = 1'b0;
    later_nonempty = 1'b0;
    for (int k = 1; k <= CLASS_COUNT; k++) begin
      if (cnt_d[CW'(k)] != '0) any_nonempty = 1'b1;
      if ((CW'(k) > cls_q) && (cnt_q[CW'(k)] != '0)) later_nonempty = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cls_q     <= '0;
      node_q    <= '0;
      last_q    <= 1'b0;
      tmo_q     <= '0;
      for (int k = 0; k <= CLASS_COUNT; k++) cnt_q[k] <= '0;
      x_q       <= '0;
      c_q       <= 0;
      x_valid_q <= 1'b0;
      done_q    <= 1'b0;
      lr_q      <= LEARNING;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      node_q    <= node_d;
      last_q    <= last_d;
      tmo_q     <= tmo_d;
      cnt_q     <= cnt_d;
      x_q       <= x_d;
      c_q       <= c_d;
      x_valid_q <= x_valid_d;
      done_q    <= done_d;
      lr_q      <= lr_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    node_d  = node_q;
    last_d  = last_q;
    tmo_d   = tmo_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          cls_d   = CW'(1);
          node_d  = NW'(1);
          last_d  = 1'b0;
          state_d = any_nonempty ? FEED : DONE;
        end
        FEED: begin
          if (cls_q > CW'(CLASS_COUNT)) begin
            state_d = DONE;
          end else if ((cur_cnt == '0) || (node_q > cur_cnt)) begin
            cls_d  = cls_q + CW'(1);
            node_d = NW'(1);
          end else if (ml.ready_wait == READY) begin
            last_d  = !later_nonempty && (node_q == cur_cnt);
            node_d  = node_q + NW'(1);
            tmo_d   = '0;
            state_d = ACK;
          end
        end
        ACK: begin
          if (ml.ready_wait == WAIT) begin
            state_d = last_q ? DONE : FEED;
          end else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
            state_d = IDLE;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    x_d       = x_q;
    c_d       = c_q;
    x_valid_d = 1'b0;
    done_d    = done_q;
    lr_d      = lr_q;
    err_d     = err_q;
    busy_d    = (state_d == FEED) || (state_d == ACK);
    if ((state_q == IDLE) && start && !abort) err_d = 1'b0;
    if (wr_reject) err_d = 1'b1;
    if (abort) begin
      done_d = 1'b0;
      lr_d   = LEARNING;
    end else begin
      if ((state_q == FEED) && (state_d == ACK)) begin
        x_d       = rd_data;
        c_d       = int'(cls_q);
        x_valid_d = 1'b1;
      end
      if ((state_q == ACK) && (state_d == IDLE)) err_d = 1'b1;
      if ((state_q == DONE) && recall_we) begin
        x_d       = recall_x;
        c_d       = 0;
        x_valid_d = 1'b1;
      end
      if (state_d == DONE) begin
        done_d = 1'b1;
        lr_d   = RECALL;
      end
    end
  end

  assign ml.x               = x_q;
  assign ml.c               = c_q;
  assign ml.x_valid         = x_valid_q;
  assign ml.learning_done   = done_q;
  assign ml.learning_recall = lr_q;
  assign busy               = busy_q;
  assign err                = err_q;

endmodule

// File: tb/tb_gam_pattern_sequencer.sv
// Directed bench for gam_pattern_sequencer: learning sequences with a toggling
// ready_wait model, class skipping, ACK timeout, recall, abort, rejected writes, mid-run reset.
module tb_gam_pattern_sequencer;
  import GAM_package::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         wr_en;
  logic [2:0]   wr_class;
  logic [4:0]   wr_node;
  node_vector_T wr_data;
  logic         cnt_we;
  logic [4:0]   cnt_data;
  logic         start;
  logic         abort;
  logic         recall_we;
  node_vector_T recall_x;
  logic         busy;
  logic         err;

  int           tests_run    = 0;
  int           tests_failed = 0;
  logic [31:0]  exp_x [$];
  int           exp_c [$];

  gam_pattern_sequencer_if ml_if ();

  gam_pattern_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_class  (wr_class),
    .wr_node   (wr_node),
    .wr_data   (wr_data),
    .cnt_we    (cnt_we),
    .cnt_data  (cnt_data),
    .start     (start),
    .abort     (abort),
    .recall_we (recall_we),
    .recall_x  (recall_x),
    .ml        (ml_if),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expected);
    tests_run++;
    if (got !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expected);
    end
  endtask

  task automatic writePattern(input logic [2:0] cls, input logic [4:0] node, input logic [31:0] data);
    wr_en = 1'b1; wr_class = cls; wr_node = node; wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic writeCount(input logic [2:0] cls, input logic [4:0] n);
    cnt_we = 1'b1; wr_class = cls; cnt_data = n;
    tick();
    cnt_we = 1'b0;
  endtask

  task automatic pulseAbort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  // Runs one learning sequence, acting as Memory_Layer: READY until a strobe, then one WAIT cycle.
  task automatic applyStimulus(input string tag);
    int  idx;
    int  cyc;
    bit  done_seen;
    idx = 0; cyc = 0; done_seen = 1'b0;
    ml_if.ready_wait = READY;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (!done_seen && cyc < 400) begin
      tick();
      cyc++;
      if (ml_if.x_valid) begin
        if (idx < exp_x.size()) begin
          checkOutput($sformatf("%s x[%0d]", tag, idx), ml_if.x, exp_x[idx]);
          checkOutput($sformatf("%s c[%0d]", tag, idx), ml_if.c, exp_c[idx]);
          checkOutput($sformatf("%s early done[%0d]", tag, idx), ml_if.learning_done, 0);
        end
        idx++;
        ml_if.ready_wait = WAIT;
        tick();
        cyc++;
        ml_if.ready_wait = READY;
      end
      if (ml_if.learning_done) done_seen = 1'b1;
    end
    checkOutput({tag, " strobes"}, idx, exp_x.size());
    checkOutput({tag, " learning_done"}, ml_if.learning_done, 1);
    checkOutput({tag, " mode"}, ml_if.learning_recall, RECALL);
    checkOutput({tag, " busy"}, busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: time limit reached, tests run %0d", tests_run);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    int strobes;

    reset = 1'b0; wr_en = 1'b0; wr_class = '0; wr_node = '0; wr_data = '0;
    cnt_we = 1'b0; cnt_data = '0; start = 1'b0; abort = 1'b0;
    recall_we = 1'b0; recall_x = '0; ml_if.ready_wait = READY;

    tick();
    checkOutput("rst x", ml_if.x, 0);
    checkOutput("rst c", ml_if.c, 0);
    checkOutput("rst x_valid", ml_if.x_valid, 0);
    checkOutput("rst done", ml_if.learning_done, 0);
    checkOutput("rst mode", ml_if.learning_recall, LEARNING);
    checkOutput("rst busy", busy, 0);
    checkOutput("rst err", err, 0);
    reset = 1'b1;
    tick();

    // One class, eight patterns
    exp_x = {32'h0003, 32'h0400, 32'h070005, 32'h1234, 32'h00F0, 32'h8001, 32'h0055, 32'h0202};
    exp_c = {1, 1, 1, 1, 1, 1, 1, 1};
    for (int i = 0; i < 8; i++) writePattern(3'd1, 5'(i + 1), exp_x[i]);
    writeCount(3'd1, 5'd8);
    applyStimulus("seq8");

    // Recall probe in DONE
    recall_x = 32'h070005; recall_we = 1'b1;
    tick();
    recall_we = 1'b0;
    checkOutput("recall x_valid", ml_if.x_valid, 1);
    checkOutput("recall x", ml_if.x, 32'h070005);
    checkOutput("recall c", ml_if.c, 0);
    checkOutput("recall mode", ml_if.learning_recall, RECALL);
    tick();
    checkOutput("recall strobe width", ml_if.x_valid, 0);

    pulseAbort();
    checkOutput("abort done", ml_if.learning_done, 0);
    checkOutput("abort mode", ml_if.learning_recall, LEARNING);
    checkOutput("abort x hold", ml_if.x, 32'h070005);

    // Counts {1:2, 2:0, 3:1}
    writePattern(3'd3, 5'd1, 32'hABCD);
    writeCount(3'd1, 5'd2);
    writeCount(3'd3, 5'd1);
    exp_x = {32'h0003, 32'h0400, 32'hABCD};
    exp_c = {1, 1, 3};
    applyStimulus("skip");

    // ACK timeout with ready_wait stuck at READY
    pulseAbort();
    ml_if.ready_wait = READY;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!ml_if.x_valid && cyc < 20) begin tick(); cyc++; end
    checkOutput("tmo first x", ml_if.x, 32'h0003);
    strobes = 0; cyc = 0;
    while (!err && cyc < 200) begin
      tick();
      cyc++;
      if (ml_if.x_valid) strobes++;
    end
    checkOutput("tmo cycles", cyc, 64);
    checkOutput("tmo extra strobes", strobes, 0);
    checkOutput("tmo err", err, 1);
    checkOutput("tmo busy", busy, 0);
    checkOutput("tmo done", ml_if.learning_done, 0);

    // Write during FEED is rejected
    ml_if.ready_wait = WAIT;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("feed err cleared", err, 0);
    checkOutput("feed busy", busy, 1);
    writePattern(3'd1, 5'd1, 32'hDEAD);
    checkOutput("feed write err", err, 1);
    pulseAbort();
    checkOutput("abort feed busy", busy, 0);

    // Abort during ACK; store must still hold the original (1,1)
    ml_if.ready_wait = READY;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("restart err cleared", err, 0);
    cyc = 0;
    while (!ml_if.x_valid && cyc < 20) begin tick(); cyc++; end
    checkOutput("store unchanged", ml_if.x, 32'h0003);
    pulseAbort();
    checkOutput("abort ack busy", busy, 0);
    checkOutput("abort ack x_valid", ml_if.x_valid, 0);
    checkOutput("abort ack x hold", ml_if.x, 32'h0003);
    checkOutput("abort ack done", ml_if.learning_done, 0);

    writePattern(3'd0, 5'd1, 32'hBEEF);
    checkOutput("class0 err", err, 1);
    applyStimulus("replay");
    checkOutput("replay err cleared", err, 0);

    // Reset asserted mid-FEED
    pulseAbort();
    ml_if.ready_wait = WAIT;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("pre-reset busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    checkOutput("midrst x", ml_if.x, 0);
    checkOutput("midrst c", ml_if.c, 0);
    checkOutput("midrst busy", busy, 0);
    checkOutput("midrst mode", ml_if.learning_recall, LEARNING);
    tick();
    reset = 1'b1;
    tick();

    // Counts were cleared by reset: start goes straight to DONE
    ml_if.ready_wait = READY;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("empty done", ml_if.learning_done, 1);
    checkOutput("empty mode", ml_if.learning_recall, RECALL);
    checkOutput("empty x_valid", ml_if.x_valid, 0);
    pulseAbort();

    writeCount(3'd1, 5'd2);
    writeCount(3'd3, 5'd1);
    applyStimulus("after reset");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
